// File: rtl/filter_msg_pkg.sv
// Message-bus definitions shared by the FIR tap loader: FSM encoding and word builders.
// `MSG_WIDTH defaults to 32 when the build does not supply it.
`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

package filter_msg_pkg;

  localparam int MsgWidth    = `MSG_WIDTH;
  localparam int MSG_HDR_BIT = MsgWidth - 1;

  typedef enum logic [1:0] {StIdle, StHdr, StTap, StWait} fsm_state_e;

  // What the gap counter releases once it expires.
  typedef enum logic [1:0] {NxTap, NxDone, NxHdr} gap_next_e;

  function automatic logic [MsgWidth-1:0] build_hdr(input logic [MsgWidth-2:0] id);
    return {1'b1, id};
  endfunction

  // raw holds a width-bit signed tap in its low bits; the header bit stays clear.
  function automatic logic [MsgWidth-1:0] build_tap(input logic [MsgWidth-2:0] raw,
                                                    input int width);
    logic [MsgWidth-1:0] w;
    logic                sgn;
    sgn = 1'b0;
    for (int i = 0; i < MsgWidth - 1; i++) begin
      if (i == width - 1) sgn = raw[i];
    end
    w = '0;
    for (int i = 0; i < MsgWidth - 1; i++) begin
      w[i] = (i < width) ? raw[i] : sgn;
    end
    return w;
  endfunction

endpackage

// File: rtl/filter_tap_bank.sv
// Shadow/active coefficient banks: host writes land in shadow, snap_i copies shadow to active,
// and the packet sequencer reads active through an indexed mux.
module filter_tap_bank #(
  parameter int unsigned TapWidth = 16,
  parameter int unsigned FltLen   = 10,
  localparam int unsigned AddrW   = $clog2(FltLen)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [AddrW-1:0]    wr_addr_i,
  input  logic [TapWidth-1:0] wr_data_i,
  input  logic                snap_i,
  input  logic [AddrW-1:0]    rd_addr_i,
  output logic [TapWidth-1:0] rd_data_o
);

  logic [TapWidth-1:0] shadow_q [FltLen];
  logic [TapWidth-1:0] shadow_d [FltLen];
  logic [TapWidth-1:0] active_q [FltLen];
  logic [TapWidth-1:0] active_d [FltLen];

  // Snapshot takes the pre-edge shadow, so a same-cycle write is not captured.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (snap_i) active_d = shadow_q;
    if (wr_en_i && (32'(wr_addr_i) < FltLen)) shadow_d[wr_addr_i] = wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FltLen); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign rd_data_o = active_q[rd_addr_i];

endmodule

// File: rtl/filter_tap_loader.sv
// Tap-setting packet sequencer: on commit, emits a header then FLTLEN tap words with GAP idle
// cycles after each word. Optional checking is enabled by FILTER_TAPLOAD_CHECK_EN.
module filter_tap_loader
  import filter_msg_pkg::*;
#(
  parameter int unsigned TAPWIDTH  = 16,
  parameter int unsigned FLTLEN    = 10,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned GAP       = 0,
  localparam int unsigned LOG_FLTLEN = $clog2(FLTLEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [LOG_FLTLEN-1:0] wr_addr,
  input  logic [TAPWIDTH-1:0]   wr_data,
  input  logic                  commit,
  input  logic [ID_WIDTH-1:0]   commit_id,
  output logic                  busy,
  output logic [MsgWidth-1:0]   out_msg,
  output logic                  out_msg_nd,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned PayW    = MsgWidth - 1;
  localparam logic [7:0]  GapInit = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  fsm_state_e            state_q, state_d;
  gap_next_e             nxt_q, nxt_d;
  logic [LOG_FLTLEN-1:0] idx_q, idx_d;
  logic                  last_q, last_d;
  logic [7:0]            gap_q, gap_d;
  logic                  pend_q, pend_d;
  logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
  logic [MsgWidth-1:0]   out_msg_q, out_msg_d;
  logic                  nd_q, nd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  go_hdr, go_tap, go_wait, go_done, snap;
  logic [ID_WIDTH-1:0]   hdr_id;
  gap_next_e             wait_nxt;
  logic [TAPWIDTH-1:0]   rd_data;
  logic [MsgWidth-1:0]   tap_word;

  filter_tap_bank #(
    .TapWidth (TAPWIDTH),
    .FltLen   (FLTLEN)
  ) u_bank (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .snap_i    (snap),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  assign tap_word = build_tap(PayW'(rd_data), int'(TAPWIDTH));

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    gap_d     = gap_q;
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    out_msg_d = '0;
    nd_d      = 1'b0;
    done_d    = 1'b0;
    go_hdr    = 1'b0;
    go_tap    = 1'b0;
    go_wait   = 1'b0;
    go_done   = 1'b0;
    snap      = 1'b0;
    hdr_id    = pend_id_q;
    wait_nxt  = NxTap;

    if (commit && busy_q && !pend_q) begin
      pend_d    = 1'b1;
      pend_id_d = commit_id;
    end

    // StIdle with done_q set is the done cycle: still busy, and it launches any queued packet.
    unique case (state_q)
      StIdle: begin
        if (!done_q) begin
          if (commit) begin
            go_hdr = 1'b1;
            hdr_id = commit_id;
          end
        end else if (pend_q || commit) begin
          if (GAP == 0) begin
            go_hdr = 1'b1;
            hdr_id = pend_q ? pend_id_q : commit_id;
          end else begin
            go_wait  = 1'b1;
            wait_nxt = NxHdr;
          end
        end
      end
      StHdr: begin
        if (GAP == 0) go_tap = 1'b1;
        else begin
          go_wait  = 1'b1;
          wait_nxt = NxTap;
        end
      end
      StTap: begin
        if (GAP == 0) begin
          go_done = last_q;
          go_tap  = !last_q;
        end else begin
          go_wait  = 1'b1;
          wait_nxt = last_q ? NxDone : NxTap;
        end
      end
      StWait: begin
        if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
        else begin
          unique case (nxt_q)
            NxTap:   go_tap  = 1'b1;
            NxHdr:   go_hdr  = 1'b1;
            default: go_done = 1'b1;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_hdr) begin
      state_d   = StHdr;
      out_msg_d = build_hdr(PayW'(hdr_id));
      nd_d      = 1'b1;
      snap      = 1'b1;
      idx_d     = '0;
      last_d    = 1'b0;
      pend_d    = 1'b0;
    end
    if (go_tap) begin
      state_d   = StTap;
      out_msg_d = tap_word;
      nd_d      = 1'b1;
      idx_d     = idx_q + 1'b1;
      last_d    = (idx_q == LOG_FLTLEN'(FLTLEN - 1));
    end
    if (go_wait) begin
      state_d = StWait;
      gap_d   = GapInit;
      nxt_d   = wait_nxt;
    end
    if (go_done) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end

    busy_d = (state_d != StIdle) || done_d;

`ifdef FILTER_TAPLOAD_CHECK_EN
    err_d = err_q | (commit && busy_q && pend_q) | (wr_en && (32'(wr_addr) >= FLTLEN));
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nxt_q     <= NxTap;
      idx_q     <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      out_msg_q <= '0;
      nd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      out_msg_q <= out_msg_d;
      nd_q      <= nd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy       = busy_q;
  assign out_msg    = out_msg_q;
  assign out_msg_nd = nd_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule
